// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
// Holds the forward-select codes, the register-address width and the slot record.
package hazard_forward_ctrl_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Destination tracking record for one pipeline slot.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              ld;
    } slot_t;

    // A slot produces src when it writes that register and src is not $0.
    function automatic logic slot_match(
        input logic [REG_AW-1:0] src,
        input slot_t             s
    );
        return s.wr && (s.rd == src) && (src != '0);
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// Combinational forward-select for one ALU operand.
// Ports: i_src/i_use (source reg), i_ex/i_mem (slots), o_code (2-bit select).
module hazard_forward_ctrl_fwd_select
    import hazard_forward_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] i_src,
    input  logic              i_use,
    input  slot_t             i_ex,
    input  slot_t             i_mem,
    output logic [1:0]        o_code
);

    logic w_ex_hit;
    logic w_mem_hit;

    // A load in EX cannot forward from EX/MEM; the stall covers that case.
    assign w_ex_hit  = slot_match(i_src, i_ex) && !i_ex.ld;
    assign w_mem_hit = slot_match(i_src, i_mem);

    always_comb begin
        o_code = FWD_REG;
        if (i_use) begin
            // Newer producer (EX) takes priority over MEM.
            if (w_ex_hit) begin
                o_code = FWD_MEM;
            end else if (w_mem_hit) begin
                o_code = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard detection and EX-operand forwarding control for a 5-stage pipeline.
// Ports: clk/rst, ID-stage operand info, flush; stall, fwd_a/fwd_b, ex_bubble, stall_count.
module hazard_forward_ctrl #(
    parameter int REG_AW = hazard_forward_ctrl_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              ex_bubble,
    output logic [CNT_W-1:0]  stall_count
);

    import hazard_forward_ctrl_pkg::*;

    slot_t            r_ex;
    slot_t            r_mem;
    logic [1:0]       r_fwd_a;
    logic [1:0]       r_fwd_b;
    logic             r_bubble;
    logic [CNT_W-1:0] r_stall_count;

    slot_t            w_id_slot;
    logic [1:0]       w_code_a;
    logic [1:0]       w_code_b;
    logic             w_rs_dep;
    logic             w_rt_dep;
    logic             w_stall;
    logic             w_advance;
    logic             w_cnt_full;

    assign w_id_slot = '{rd: id_rd, wr: id_reg_write, ld: id_mem_read};

    // Load in EX feeding an ID source: one bubble, then forward from WB.
    assign w_rs_dep = id_use_rs && (r_ex.rd == id_rs);
    assign w_rt_dep = id_use_rt && (r_ex.rd == id_rt);

    assign w_stall = !rst && !flush && id_valid
                   && r_ex.ld && r_ex.wr && (r_ex.rd != '0)
                   && (w_rs_dep || w_rt_dep);

    assign w_advance  = id_valid && !w_stall && !flush;
    assign w_cnt_full = (r_stall_count == {CNT_W{1'b1}});

    hazard_forward_ctrl_fwd_select u_sel_a (
        .i_src  (id_rs),
        .i_use  (id_use_rs),
        .i_ex   (r_ex),
        .i_mem  (r_mem),
        .o_code (w_code_a)
    );

    hazard_forward_ctrl_fwd_select u_sel_b (
        .i_src  (id_rt),
        .i_use  (id_use_rt),
        .i_ex   (r_ex),
        .i_mem  (r_mem),
        .o_code (w_code_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex          <= '0;
            r_mem         <= '0;
            r_fwd_a       <= FWD_REG;
            r_fwd_b       <= FWD_REG;
            r_bubble      <= 1'b1;
            r_stall_count <= '0;
        end else begin
            r_mem <= r_ex;
            if (w_advance) begin
                r_ex     <= w_id_slot;
                r_fwd_a  <= w_code_a;
                r_fwd_b  <= w_code_b;
                r_bubble <= 1'b0;
            end else begin
                r_ex     <= '0;
                r_fwd_a  <= FWD_REG;
                r_fwd_b  <= FWD_REG;
                r_bubble <= 1'b1;
            end
            if (w_stall && !w_cnt_full) begin
                r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign stall       = w_stall;
    assign fwd_a       = r_fwd_a;
    assign fwd_b       = r_fwd_b;
    assign ex_bubble   = r_bubble;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed self-checking bench for hazard_forward_ctrl.
// A second narrow-counter instance shares the stimulus to exercise saturation.
module tb_hazard_forward_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        flush;

    logic        stall;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        ex_bubble;
    logic [15:0] stall_count;

    logic        s_stall;
    logic [1:0]  s_fwd_a;
    logic [1:0]  s_fwd_b;
    logic        s_ex_bubble;
    logic [1:0]  s_stall_count;

    int n_checks;
    int n_errors;

    hazard_forward_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .stall        (stall),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .ex_bubble    (ex_bubble),
        .stall_count  (stall_count)
    );

    hazard_forward_ctrl #(.REG_AW(5), .CNT_W(2)) u_sat (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .stall        (s_stall),
        .fwd_a        (s_fwd_a),
        .fwd_b        (s_fwd_b),
        .ex_bubble    (s_ex_bubble),
        .stall_count  (s_stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(
        input logic       v,
        input logic [4:0] rs,
        input logic       urs,
        input logic [4:0] rt,
        input logic       urt,
        input logic [4:0] rd,
        input logic       rw,
        input logic       mr
    );
        id_valid     = v;
        id_rs        = rs;
        id_use_rs    = urs;
        id_rt        = rt;
        id_use_rt    = urt;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        flush = 1'b0;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        n_checks++;
        if (fwd_a !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_fwd_a got %b want 00", fwd_a);
        end
        n_checks++;
        if (fwd_b !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_fwd_b got %b want 00", fwd_b);
        end
        n_checks++;
        if (ex_bubble !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_bubble got %b want 1", ex_bubble);
        end
        n_checks++;
        if (stall_count !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_count got %0d want 0", stall_count);
        end
        n_checks++;
        if (stall !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_stall got %b want 0", stall);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_idle();
        set_id(1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (ex_bubble !== 1'b1) begin
            n_errors++;
            $display("FAIL idle_bubble got %b want 1", ex_bubble);
        end
    endtask

    task automatic test_back_to_back();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (ex_bubble !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_bubble got %b want 0", ex_bubble);
        end
        set_id(1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
        n_checks++;
        if (stall !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_stall got %b want 0", stall);
        end
        tick();
        n_checks++;
        if (fwd_a !== 2'b10) begin
            n_errors++;
            $display("FAIL b2b_fwd_a got %b want 10", fwd_a);
        end
        n_checks++;
        if (fwd_b !== 2'b00) begin
            n_errors++;
            $display("FAIL b2b_fwd_b got %b want 00", fwd_b);
        end
    endtask

    task automatic test_distance2();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (fwd_b !== 2'b01) begin
            n_errors++;
            $display("FAIL dist2_fwd_b got %b want 01", fwd_b);
        end
        n_checks++;
        if (fwd_a !== 2'b00) begin
            n_errors++;
            $display("FAIL dist2_fwd_a got %b want 00", fwd_a);
        end
    endtask

    task automatic test_double_producer();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 5'd9, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (fwd_a !== 2'b10) begin
            n_errors++;
            $display("FAIL double_fwd_a got %b want 10", fwd_a);
        end
    endtask

    task automatic test_load_use();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        n_checks++;
        if (stall !== 1'b1) begin
            n_errors++;
            $display("FAIL lu_stall got %b want 1", stall);
        end
        tick();
        n_checks++;
        if (ex_bubble !== 1'b1 || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            n_errors++;
            $display("FAIL lu_bubble got bub=%b a=%b b=%b want 1 00 00",
                     ex_bubble, fwd_a, fwd_b);
        end
        n_checks++;
        if (stall_count !== 16'd1) begin
            n_errors++;
            $display("FAIL lu_count got %0d want 1", stall_count);
        end
        n_checks++;
        if (stall !== 1'b0) begin
            n_errors++;
            $display("FAIL lu_stall_once got %b want 0", stall);
        end
        tick();
        n_checks++;
        if (fwd_a !== 2'b01 || ex_bubble !== 1'b0) begin
            n_errors++;
            $display("FAIL lu_fwd_a got a=%b bub=%b want 01 0",
                     fwd_a, ex_bubble);
        end
    endtask

    task automatic test_zero_and_flush();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1);
        tick();
        n_checks++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            n_errors++;
            $display("FAIL zero_ex_fwd got a=%b b=%b want 00 00", fwd_a, fwd_b);
        end
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);
        n_checks++;
        if (stall !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_ld_stall got %b want 0", stall);
        end
        tick();
        n_checks++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            n_errors++;
            $display("FAIL zero_mem_fwd got a=%b b=%b want 00 00", fwd_a, fwd_b);
        end
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_stall got %b want 0", stall);
        end
        tick();
        flush = 1'b0;
        n_checks++;
        if (ex_bubble !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_bubble got %b want 1", ex_bubble);
        end
        n_checks++;
        if (stall_count !== 16'd1) begin
            n_errors++;
            $display("FAIL flush_count got %0d want 1", stall_count);
        end
    endtask

    task automatic test_reset_mid_stall();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 5'd8, 1'b1, 1'b0);
        n_checks++;
        if (stall !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_pre_stall got %b want 1", stall);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_stall got %b want 0", stall);
        end
        tick();
        rst = 1'b0;
        n_checks++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || ex_bubble !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_state got a=%b b=%b bub=%b want 00 00 1",
                     fwd_a, fwd_b, ex_bubble);
        end
        n_checks++;
        if (stall_count !== 16'd0 || s_stall_count !== 2'd0) begin
            n_errors++;
            $display("FAIL rst_count got %0d/%0d want 0/0",
                     stall_count, s_stall_count);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 5; i++) begin
            set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
            tick();
            set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
            tick();
            set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
            tick();
        end
        n_checks++;
        if (stall_count !== 16'd5) begin
            n_errors++;
            $display("FAIL sat_wide got %0d want 5", stall_count);
        end
        n_checks++;
        if (s_stall_count !== 2'd3) begin
            n_errors++;
            $display("FAIL sat_narrow got %0d want 3", s_stall_count);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_idle();
        test_back_to_back();
        test_distance2();
        test_double_producer();
        test_load_use();
        test_zero_and_flush();
        test_reset_mid_stall();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
